// File: rtl/ledfb_rgb565.sv
// RGB565 frame buffer for a two-half scanned LED panel: writer port, scanner read port,
// optional frame-synchronous double buffering enabled by macro LEDFB_DOUBLE_BUFFER_EN.
module ledfb_rgb565 #(
    parameter int XBITS = 6,
    parameter int YBITS = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [XBITS-1:0] wr_x,
    input  logic [YBITS:0]   wr_y,
    input  logic [15:0]      wr_data,
    input  logic             swap_req,
    output logic             swap_done,
    input  logic             frame_sync,
    input  logic [XBITS-1:0] addrx,
    input  logic [YBITS-1:0] addry,
    output logic [7:0]       r0,
    output logic [7:0]       g0,
    output logic [7:0]       b0,
    output logic [7:0]       r1,
    output logic [7:0]       g1,
    output logic [7:0]       b1
);

`ifdef LEDFB_DOUBLE_BUFFER_EN
    localparam int ABITS = XBITS + YBITS + 1;
`else
    localparam int ABITS = XBITS + YBITS;
`endif
    localparam int DEPTH = 1 << ABITS;

    logic [15:0]      mem_u [DEPTH];
    logic [15:0]      mem_l [DEPTH];
    logic [ABITS-1:0] wr_addr;
    logic [ABITS-1:0] rd_addr;
    logic             rdy_en;
    logic             wr_fire;

    function automatic logic [7:0] exp5(input logic [4:0] v);
        return {v, v[4:2]};
    endfunction

    function automatic logic [7:0] exp6(input logic [5:0] v);
        return {v, v[5:4]};
    endfunction

    // Holds wr_ready low while reset is asserted; rises on the first clock after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_en <= 1'b0;
        else        rdy_en <= 1'b1;
    end

`ifdef LEDFB_DOUBLE_BUFFER_EN
    typedef enum logic {IDLE, PENDING} state_t;

    state_t state;
    state_t state_nxt;
    logic   front_sel;
    logic   front_rd;
    logic   fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            front_sel <= 1'b0;
            swap_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            front_sel <= front_sel ^ fire;
            swap_done <= fire;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (swap_req)   state_nxt = PENDING;
            PENDING: if (frame_sync) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Reads in the frame_sync cycle already use the new front buffer, so the swap
    // appears on the outputs together with swap_done.
    always_comb begin
        fire     = (state == PENDING) && frame_sync;
        front_rd = front_sel ^ fire;
        wr_ready = rdy_en && (state == IDLE);
    end

    assign wr_addr = {~front_sel, wr_y[YBITS-1:0], wr_x};
    assign rd_addr = {front_rd, addry, addrx};
`else
    logic unused_frame_sync;
    assign unused_frame_sync = frame_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) swap_done <= 1'b0;
        else        swap_done <= swap_req;
    end

    assign wr_ready = rdy_en;
    assign wr_addr  = {wr_y[YBITS-1:0], wr_x};
    assign rd_addr  = {addry, addrx};
`endif

    assign wr_fire = wr_valid && wr_ready;

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            if (wr_y[YBITS]) mem_l[wr_addr] <= wr_data;
            else             mem_u[wr_addr] <= wr_data;
        end
    end

    // Registered read: a same-cycle write to the read address returns the old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r0 <= '0; g0 <= '0; b0 <= '0;
            r1 <= '0; g1 <= '0; b1 <= '0;
        end else begin
            r0 <= exp5(mem_u[rd_addr][15:11]);
            g0 <= exp6(mem_u[rd_addr][10:5]);
            b0 <= exp5(mem_u[rd_addr][4:0]);
            r1 <= exp5(mem_l[rd_addr][15:11]);
            g1 <= exp6(mem_l[rd_addr][10:5]);
            b1 <= exp5(mem_l[rd_addr][4:0]);
        end
    end

endmodule
